// File: rtl/cva6_pma_unit_pkg.sv
// Shared types and constants for the programmable PMA unit.
// Rule table entries carry 64-bit base/len and are truncated to the unit's address width.
package cva6_pma_unit_pkg;

    typedef struct packed {
        logic nonidem;
        logic exec;
        logic cache;
        logic lock;
    } pma_attr_t;

    typedef struct packed {
        logic [63:0] base;
        logic [63:0] len;
        pma_attr_t   attr;
    } pma_rule_t;

    typedef enum logic {
        CfgIdle,
        CfgCommit
    } pma_cfg_state_e;

    localparam int unsigned PmaMaxRules = 32;

    // Attributes returned when no rule matches: treat as non-idempotent I/O.
    localparam pma_attr_t PmaMissAttr = '{nonidem: 1'b1, exec: 1'b0, cache: 1'b0, lock: 1'b0};

    // Width of a rule index; never zero so single-rule tables still have a port.
    function automatic int unsigned pma_idx_w(input int unsigned nr_rules);
        return (nr_rules > 1) ? $clog2(nr_rules) : 1;
    endfunction

endpackage

// File: rtl/cva6_pma_unit_if.sv
// Configuration and lookup bus of the PMA unit.
// master: CSR file / MMU side, slave: the PMA unit.
interface cva6_pma_unit_if
    import cva6_pma_unit_pkg::*;
#(
    parameter int unsigned NrRules   = 16,
    parameter int unsigned NrPorts   = 2,
    parameter int unsigned AddrWidth = 64
);
    localparam int unsigned IdxW = pma_idx_w(NrRules);

    logic                                cfg_valid_i;
    logic                                cfg_ready_o;
    logic [IdxW-1:0]                     cfg_idx_i;
    pma_rule_t                           cfg_rule_i;
    logic                                cfg_done_o;
    logic                                cfg_err_o;
    logic [NrPorts-1:0]                  req_valid_i;
    logic [NrPorts-1:0][AddrWidth-1:0]   req_addr_i;
    logic [NrPorts-1:0]                  rsp_valid_o;
    logic [NrPorts-1:0]                  rsp_hit_o;
    logic [NrPorts-1:0][IdxW-1:0]        rsp_idx_o;
    pma_attr_t [NrPorts-1:0]             rsp_attr_o;

    modport master (
        output cfg_valid_i, cfg_idx_i, cfg_rule_i, req_valid_i, req_addr_i,
        input  cfg_ready_o, cfg_done_o, cfg_err_o,
               rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_attr_o
    );

    modport slave (
        input  cfg_valid_i, cfg_idx_i, cfg_rule_i, req_valid_i, req_addr_i,
        output cfg_ready_o, cfg_done_o, cfg_err_o,
               rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_attr_o
    );

endinterface

// File: rtl/cva6_pma_unit_match.sv
// Combinational lookup of one address against the whole rule table.
// Lowest matching index wins; a miss returns the safe default attributes.
module cva6_pma_match
    import cva6_pma_unit_pkg::*;
#(
    parameter int unsigned NrRules   = 16,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned IdxW      = 4
) (
    input  logic [AddrWidth-1:0]  addr_i,
    input  pma_rule_t [NrRules-1:0] rules_i,
    output logic                  hit_o,
    output logic [IdxW-1:0]       idx_o,
    output pma_attr_t             attr_o
);

    logic [NrRules-1:0] match;

    for (genvar g = 0; g < NrRules; g++) begin : g_rule
        logic [AddrWidth-1:0] base;
        logic [AddrWidth-1:0] len;
        logic [AddrWidth:0]   limit;

        assign base  = rules_i[g].base[AddrWidth-1:0];
        assign len   = rules_i[g].len[AddrWidth-1:0];
        // One extra bit keeps a limit past the top of the address space from wrapping.
        assign limit = {1'b0, base} + {1'b0, len};
        assign match[g] = (len != '0) && (addr_i >= base) && ({1'b0, addr_i} < limit);
    end

    // Priority encode: scan from the highest index down so the lowest match is kept.
    always_comb begin
        hit_o  = 1'b0;
        idx_o  = '0;
        attr_o = PmaMissAttr;
        for (int unsigned i = NrRules; i > 0; i--) begin
            if (match[i-1]) begin
                hit_o  = 1'b1;
                idx_o  = IdxW'(i - 1);
                attr_o = rules_i[i-1].attr;
            end
        end
    end

endmodule

// File: rtl/cva6_pma_unit.sv
// Programmable PMA unit: writable priority-ordered rule table with NrPorts
// registered lookup channels.
// Optional feature macro: CVA6_PMA_LOCK_EN (locked rules reject writes until reset).
module cva6_pma_unit
    import cva6_pma_unit_pkg::*;
#(
    parameter int unsigned          NrRules   = 16,
    parameter int unsigned          NrPorts   = 2,
    parameter int unsigned          AddrWidth = 64,
    parameter pma_rule_t [NrRules-1:0] RstRules = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    cva6_pma_unit_if.slave   bus
);

    localparam int unsigned IdxW = pma_idx_w(NrRules);

`ifdef CVA6_PMA_LOCK_EN
    localparam bit LockEn = 1'b1;
`else
    localparam bit LockEn = 1'b0;
`endif

    pma_cfg_state_e          state_q;
    logic                    ready_q;
    logic                    done_q;
    logic                    err_q;
    logic [IdxW-1:0]         cfg_idx_q;
    pma_rule_t               cfg_rule_q;
    pma_rule_t [NrRules-1:0] table_q;

    logic                    out_of_range;
    logic                    target_locked;
    logic                    reject;

    // Decide whether the captured write must be refused.
    always_comb begin
        out_of_range  = 32'(cfg_idx_q) >= NrRules;
        target_locked = 1'b0;
        for (int unsigned i = 0; i < NrRules; i++) begin
            if (cfg_idx_q == IdxW'(i)) begin
                target_locked = table_q[i].attr.lock;
            end
        end
        reject = out_of_range || (LockEn && target_locked);
    end

    // Configuration FSM with registered handshake outputs and the rule table.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= CfgIdle;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cfg_idx_q  <= '0;
            cfg_rule_q <= '0;
            table_q    <= RstRules;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                CfgIdle: begin
                    if (bus.cfg_valid_i && ready_q) begin
                        cfg_idx_q  <= bus.cfg_idx_i;
                        cfg_rule_q <= bus.cfg_rule_i;
                        ready_q    <= 1'b0;
                        state_q    <= CfgCommit;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                CfgCommit: begin
                    for (int unsigned i = 0; i < NrRules; i++) begin
                        if (!reject && cfg_idx_q == IdxW'(i)) begin
                            table_q[i] <= cfg_rule_q;
                        end
                    end
                    done_q  <= 1'b1;
                    err_q   <= reject;
                    ready_q <= 1'b1;
                    state_q <= CfgIdle;
                end
                default: begin
                    state_q <= CfgIdle;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cfg_ready_o = ready_q;
    assign bus.cfg_done_o  = done_q;
    assign bus.cfg_err_o   = err_q;

    logic      m_hit  [NrPorts];
    logic [IdxW-1:0] m_idx [NrPorts];
    pma_attr_t m_attr [NrPorts];

    for (genvar p = 0; p < NrPorts; p++) begin : g_port
        cva6_pma_match #(
            .NrRules   (NrRules),
            .AddrWidth (AddrWidth),
            .IdxW      (IdxW)
        ) i_match (
            .addr_i  (bus.req_addr_i[p]),
            .rules_i (table_q),
            .hit_o   (m_hit[p]),
            .idx_o   (m_idx[p]),
            .attr_o  (m_attr[p])
        );
    end

    logic [NrPorts-1:0]           rsp_valid_q;
    logic [NrPorts-1:0]           rsp_hit_q;
    logic [NrPorts-1:0][IdxW-1:0] rsp_idx_q;
    pma_attr_t [NrPorts-1:0]      rsp_attr_q;

    // Per-channel response registers; payload holds while no request arrives.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rsp_valid_q <= '0;
            rsp_hit_q   <= '0;
            rsp_idx_q   <= '0;
            for (int unsigned p = 0; p < NrPorts; p++) begin
                rsp_attr_q[p] <= PmaMissAttr;
            end
        end else begin
            rsp_valid_q <= bus.req_valid_i;
            for (int unsigned p = 0; p < NrPorts; p++) begin
                if (bus.req_valid_i[p]) begin
                    rsp_hit_q[p]  <= m_hit[p];
                    rsp_idx_q[p]  <= m_idx[p];
                    rsp_attr_q[p] <= m_attr[p];
                end
            end
        end
    end

    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_hit_o   = rsp_hit_q;
    assign bus.rsp_idx_o   = rsp_idx_q;
    assign bus.rsp_attr_o  = rsp_attr_q;

endmodule
